vga_controller: RTL and testbench

Display timing generator and pixel output stage for the 2048 VGA path. Produces the raw scan coordinates `x`/`y` consumed by the board renderer. Samples the renderer's 1-bit `pixel` answer and drives the DAC-side signals: `vga_clk`, `hsync`, `vsync`, `blank_n`, `sync_n` and 8-bit R/G/B. Runs 640x480@60 from the 50 MHz board clock using an internal divide-by-2 pixel enable.

---
 rtl/vga_if.sv | 30 +++
 rtl/vga_controller.sv | 128 ++++++++++++
 tb/tb_vga_controller.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_if.sv
// VGA scan bundle: coordinates out to the renderer, pixel back in,
// DAC signals out. master = timing generator, slave = renderer/DAC.
interface vga_if;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        pixel;
  logic        vga_clk;
  logic        hsync;
  logic        vsync;
  logic        blank_n;
  logic        sync_n;
  logic        frame_done;
  logic [7:0]  r;
  logic [7:0]  g;
  logic [7:0]  b;

  modport master (
    input  pixel,
    output x, y, vga_clk, hsync, vsync,
    output blank_n, sync_n, frame_done,
    output r, g, b
  );

  modport slave (
    output pixel,
    input  x, y, vga_clk, hsync, vsync,
    input  blank_n, sync_n, frame_done,
    input  r, g, b
  );
endinterface

// File: rtl/vga_controller.sv
// VGA timing generator + pixel output stage (clk/2 pixel enable).
// Ports: clk, rst (async, active-low), bus (vga_if.master).
module vga_controller #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter logic [23:0] FG_COLOR = 24'hFFFFFF,
  parameter logic [23:0] BG_COLOR = 24'h000000
) (
  input  logic  clk,
  input  logic  rst,
  vga_if.master bus
);

  localparam int unsigned H_TOTAL =
    H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL =
    V_ACTIVE + V_FP + V_SYNC + V_BP;

  // 11-bit compares so a sync end of 1024 stays exact
  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS  = 11'(H_ACTIVE);
  localparam logic [10:0] V_VIS  = 11'(V_ACTIVE);
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END =
    11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END =
    11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0]  V_FD   = 10'(V_ACTIVE);

  logic        pix_en;
  logic [9:0]  h;
  logic [9:0]  v;
  logic [9:0]  h_nxt;
  logic [9:0]  v_nxt;
  logic [10:0] h_w;
  logic [10:0] v_w;
  logic        h_wrap;
  logic        v_wrap;
  logic        act;
  logic        hs_n;
  logic        vs_n;
  logic [23:0] rgb_nxt;

  logic        hsync_q;
  logic        vsync_q;
  logic        blank_q;
  logic        fd_q;
  logic [23:0] rgb_q;

  assign h_w = {1'b0, h};
  assign v_w = {1'b0, v};

  always_comb begin
    h_wrap = (h_w == H_LAST);
    v_wrap = (v_w == V_LAST);
    h_nxt  = h_wrap ? 10'd0 : h + 10'd1;
    v_nxt  = v;
    if (h_wrap) begin
      v_nxt = v_wrap ? 10'd0 : v + 10'd1;
    end
  end

  assign hs_n = !((h_w >= HS_BEG) && (h_w < HS_END));
  assign vs_n = !((v_w >= VS_BEG) && (v_w < VS_END));
  assign act  = (h_w < H_VIS) && (v_w < V_VIS);

  always_comb begin
    rgb_nxt = 24'h000000;
    if (act) begin
      rgb_nxt = bus.pixel ? FG_COLOR : BG_COLOR;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_en <= 1'b0;
      h      <= 10'd0;
      v      <= 10'd0;
    end else begin
      pix_en <= !pix_en;
      if (pix_en) begin
        h <= h_nxt;
        v <= v_nxt;
      end
    end
  end

  // outputs sample the pre-update h/v, so they trail x/y by one pixel
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      blank_q <= 1'b0;
      fd_q    <= 1'b0;
      rgb_q   <= 24'h000000;
    end else begin
      fd_q <= 1'b0;
      if (pix_en) begin
        hsync_q <= hs_n;
        vsync_q <= vs_n;
        blank_q <= act;
        rgb_q   <= rgb_nxt;
        fd_q    <= (h_nxt == 10'd0) && (v_nxt == V_FD);
      end
    end
  end

  assign bus.x          = h;
  assign bus.y          = v;
  assign bus.vga_clk    = pix_en;
  assign bus.hsync      = hsync_q;
  assign bus.vsync      = vsync_q;
  assign bus.blank_n    = blank_q;
  assign bus.sync_n     = 1'b0;
  assign bus.frame_done = fd_q;
  assign bus.r          = rgb_q[23:16];
  assign bus.g          = rgb_q[15:8];
  assign bus.b          = rgb_q[7:0];

endmodule

// File: tb/tb_vga_controller.sv
// Bench for vga_controller: a scaled-timing instance fully checked
// over whole frames, plus a default instance checked on line timing.
module tb_vga_controller;

  localparam int SHA = 16;
  localparam int SHF = 4;
  localparam int SHS = 6;
  localparam int SHB = 6;
  localparam int SVA = 12;
  localparam int SVF = 2;
  localparam int SVS = 2;
  localparam int SVB = 3;
  localparam int SHT = SHA + SHF + SHS + SHB;
  localparam int SVT = SVA + SVF + SVS + SVB;
  localparam logic [23:0] SFG = 24'hA5C3F0;
  localparam logic [23:0] SBG = 24'h123456;
  localparam logic [49:0] RST_V =
    {10'd0, 10'd0, 6'b011000, 24'h0};

  logic clk = 1'b0;
  logic rst = 1'b0;
  int unsigned kc;
  int vec = 0;
  int err = 0;

  int          pmode = 3;
  int unsigned pseed = 0;
  int          ppx = 0;
  int          ppy = 0;

  vga_if sif ();
  vga_if dif ();

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst) begin
    if (!rst) kc <= 0;
    else kc <= kc + 1;
  end

  function automatic logic pix_fn(
    int m, int unsigned s, int px, int py, int x, int y);
    logic [31:0] hv;
    hv = (32'(x) * 32'h9E3779B1)
       ^ (32'(y) * 32'h85EBCA6B) ^ s;
    hv = hv ^ (hv >> 13);
    case (m)
      0: return hv[5];
      1: return (x == px) && (y == py);
      2: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  assign sif.pixel = pix_fn(pmode, pseed, ppx, ppy,
                            int'(sif.x), int'(sif.y));
  assign dif.pixel = pix_fn(pmode, pseed, ppx, ppy,
                            int'(dif.x), int'(dif.y));

  vga_controller #(
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
    .FG_COLOR(SFG), .BG_COLOR(SBG)
  ) dut_s (
    .clk(clk),
    .rst(rst),
    .bus(sif)
  );

  vga_controller dut_d (
    .clk(clk),
    .rst(rst),
    .bus(dif)
  );

  // Expected outputs after k clk edges since reset release.
  // Updates happen on even edges, so n = k/2 updates are done;
  // x/y show position n, registered outputs show position n-1.
  function automatic logic [49:0] model(
    int unsigned k, int ha, int hf, int hs, int hb,
    int va, int vf, int vs, int vb,
    logic [23:0] fg, logic [23:0] bg);
    int ht, vt, fr, n, p, q, qh, qv;
    logic hso, vso, bl, fd;
    logic [23:0] c;
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    fr = ht * vt;
    n = int'(k / 2);
    p = n % fr;
    hso = 1'b1; vso = 1'b1; bl = 1'b0; fd = 1'b0;
    c = 24'h0;
    if (n > 0) begin
      q = (n - 1) % fr;
      qh = q % ht;
      qv = q / ht;
      hso = !(qh >= ha + hf && qh < ha + hf + hs);
      vso = !(qv >= va + vf && qv < va + vf + vs);
      bl = (qh < ha) && (qv < va);
      if (bl)
        c = pix_fn(pmode, pseed, ppx, ppy, qh, qv) ? fg : bg;
      fd = (k % 2 == 0) && (p == va * ht);
    end
    return {10'(p % ht), 10'(p / ht), 1'(k % 2),
            hso, vso, bl, 1'b0, fd, c};
  endfunction

  function automatic logic [49:0] model_s(int unsigned k);
    return model(k, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB,
                 SFG, SBG);
  endfunction

  function automatic logic [49:0] model_d(int unsigned k);
    return model(k, 640, 16, 96, 48, 480, 10, 2, 33,
                 24'hFFFFFF, 24'h000000);
  endfunction

  function automatic logic [49:0] obs_s();
    return {sif.x, sif.y, sif.vga_clk, sif.hsync, sif.vsync,
            sif.blank_n, sif.sync_n, sif.frame_done,
            sif.r, sif.g, sif.b};
  endfunction

  function automatic logic [49:0] obs_d();
    return {dif.x, dif.y, dif.vga_clk, dif.hsync, dif.vsync,
            dif.blank_n, dif.sync_n, dif.frame_done,
            dif.r, dif.g, dif.b};
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    pmode = 3;
    repeat (5) @(negedge clk);
    vec++;
    if (obs_s() !== RST_V) begin
      err++;
      $display("FAIL reset_s got %h want %h", obs_s(), RST_V);
    end
    vec++;
    if (obs_d() !== RST_V) begin
      err++;
      $display("FAIL reset_d got %h want %h", obs_d(), RST_V);
    end
    rst = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      vec++;
      if (sif.vga_clk !== 1'(i % 2)) begin
        err++;
        $display("FAIL vga_clk edge %0d got %b want %b",
                 i, sif.vga_clk, 1'(i % 2));
      end
      vec++;
      if (sif.x !== 10'(i / 2)) begin
        err++;
        $display("FAIL x_start edge %0d got %0d want %0d",
                 i, sif.x, i / 2);
      end
    end
  endtask

  task automatic test_random_scan();
    int ncyc;
    logic [49:0] es, ed;
    pmode = 0;
    pseed = $urandom;
    do_reset();
    ncyc = $urandom_range(2 * SHT * SVT * 2, 3 * SHT * SVT * 2);
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      es = model_s(kc);
      ed = model_d(kc);
      vec++;
      if (obs_s() !== es) begin
        err++;
        $display("FAIL scan_s k=%0d got %h want %h",
                 kc, obs_s(), es);
      end
      vec++;
      if (obs_d() !== ed) begin
        err++;
        $display("FAIL scan_d k=%0d got %h want %h",
                 kc, obs_d(), ed);
      end
    end
  endtask

  task automatic test_single_pixel();
    int fgn;
    logic [49:0] es;
    pmode = 1;
    ppx = $urandom_range(0, SHA - 1);
    ppy = $urandom_range(0, SVA - 1);
    do_reset();
    fgn = 0;
    for (int i = 0; i < 2 * SHT * SVT; i++) begin
      @(negedge clk);
      es = model_s(kc);
      vec++;
      if (obs_s() !== es) begin
        err++;
        $display("FAIL pix_s k=%0d got %h want %h",
                 kc, obs_s(), es);
      end
      if ({sif.r, sif.g, sif.b} == SFG) fgn++;
    end
    vec++;
    if (fgn !== 2) begin
      err++;
      $display("FAIL pix_count got %0d want 2", fgn);
    end
  endtask

  task automatic test_force_pixel();
    logic [49:0] es;
    pmode = 2;
    do_reset();
    for (int i = 0; i < 2 * SHT * SVT + 20; i++) begin
      @(negedge clk);
      es = model_s(kc);
      vec++;
      if (obs_s() !== es) begin
        err++;
        $display("FAIL force_s k=%0d got %h want %h",
                 kc, obs_s(), es);
      end
      if (!sif.blank_n) begin
        vec++;
        if ({sif.r, sif.g, sif.b} !== 24'h0) begin
          err++;
          $display("FAIL blank_rgb k=%0d got %h want 000000",
                   kc, {sif.r, sif.g, sif.b});
        end
      end
    end
  endtask

  task automatic test_timing();
    int hf[$];
    int vf[$];
    int hl, bh, vl, fdn;
    logic ph, pv;
    pmode = 0;
    pseed = $urandom;
    do_reset();
    hl = 0; bh = 0; vl = 0; fdn = 0;
    ph = 1'b1; pv = 1'b1;
    for (int i = 0; i < 3 * 2 * SHT * SVT + 50; i++) begin
      @(negedge clk);
      if (ph && !sif.hsync) hf.push_back(int'(kc));
      if (pv && !sif.vsync) vf.push_back(int'(kc));
      ph = sif.hsync;
      pv = sif.vsync;
      if (hf.size() == 1) begin
        if (!sif.hsync) hl++;
        if (sif.blank_n) bh++;
      end
      if (vf.size() == 1) begin
        if (!sif.vsync) vl++;
        if (sif.frame_done) begin
          fdn++;
          vec++;
          if (sif.x !== 10'd0 || sif.y !== 10'(SVA)) begin
            err++;
            $display("FAIL fd_pos got %0d,%0d want 0,%0d",
                     sif.x, sif.y, SVA);
          end
        end
      end
    end
    vec++;
    if (hf.size() < 2 || hf[1] - hf[0] !== 2 * SHT) begin
      err++;
      $display("FAIL hs_period got %0d falls want %0d clks",
               hf.size(), 2 * SHT);
    end
    vec++;
    if (hl !== 2 * SHS) begin
      err++;
      $display("FAIL hs_low got %0d want %0d", hl, 2 * SHS);
    end
    vec++;
    if (bh !== 2 * SHA) begin
      err++;
      $display("FAIL blank_hi got %0d want %0d", bh, 2 * SHA);
    end
    vec++;
    if (vf.size() < 2 || vf[1] - vf[0] !== 2 * SHT * SVT) begin
      err++;
      $display("FAIL vs_period got %0d falls want %0d clks",
               vf.size(), 2 * SHT * SVT);
    end
    vec++;
    if (vl !== 2 * SVS * SHT) begin
      err++;
      $display("FAIL vs_low got %0d want %0d", vl, 2 * SVS * SHT);
    end
    vec++;
    if (fdn !== 1) begin
      err++;
      $display("FAIL fd_count got %0d want 1", fdn);
    end
  endtask

  task automatic test_wrap();
    int wy[2];
    int ny[2];
    bit hit;
    wy[0] = SVT - 1;
    ny[0] = 0;
    wy[1] = $urandom_range(1, SVT - 2);
    ny[1] = wy[1] + 1;
    pmode = 3;
    do_reset();
    for (int t = 0; t < 2; t++) begin
      hit = 1'b0;
      for (int i = 0; i < 2 * SHT * SVT + 10 && !hit; i++) begin
        @(negedge clk);
        hit = (sif.x == 10'(SHT - 1)) && (sif.y == 10'(wy[t]));
      end
      vec++;
      if (!hit) begin
        err++;
        $display("FAIL wrap_wait%0d got timeout want %0d,%0d",
                 t, SHT - 1, wy[t]);
      end else begin
        repeat (2) @(negedge clk);
        if (sif.x !== 10'd0 || sif.y !== 10'(ny[t])) begin
          err++;
          $display("FAIL wrap%0d got %0d,%0d want 0,%0d",
                   t, sif.x, sif.y, ny[t]);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    int rx, ry, c;
    bit hit;
    rx = $urandom_range(0, SHT - 1);
    ry = $urandom_range(1, SVT - 1);
    pmode = 2;
    do_reset();
    hit = 1'b0;
    for (int i = 0; i < 2 * SHT * SVT + 10 && !hit; i++) begin
      @(negedge clk);
      hit = (sif.x == 10'(rx)) && (sif.y == 10'(ry));
    end
    vec++;
    if (!hit) begin
      err++;
      $display("FAIL mid_wait got timeout want %0d,%0d", rx, ry);
    end
    rst = 1'b0;
    #1;
    vec++;
    if (obs_s() !== RST_V) begin
      err++;
      $display("FAIL mid_rst_s got %h want %h", obs_s(), RST_V);
    end
    vec++;
    if (obs_d() !== RST_V) begin
      err++;
      $display("FAIL mid_rst_d got %h want %h", obs_d(), RST_V);
    end
    repeat (5) @(negedge clk);
    vec++;
    if (obs_s() !== RST_V) begin
      err++;
      $display("FAIL mid_hold got %h want %h", obs_s(), RST_V);
    end
    rst = 1'b1;
    c = 0;
    hit = 1'b0;
    while (!hit && c < 4 * SHT) begin
      @(posedge clk);
      #1;
      c++;
      hit = (sif.y == 10'd1);
    end
    vec++;
    if (c !== 2 * SHT) begin
      err++;
      $display("FAIL mid_line got %0d clks want %0d", c, 2 * SHT);
    end
  endtask

  initial begin
    test_reset();
    test_random_scan();
    test_single_pixel();
    test_force_pixel();
    test_timing();
    test_wrap();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==",
             vec, err);
    $finish;
  end

endmodule
